weight_stream_ctrl: RTL
=======================

# weight_stream_ctrl

Read sequencer for a packed dual-port weight ROM (16 words × 128 bit, 1-cycle registered read). On a start pulse it streams every packed 16-bit weight, one per beat, over a valid/ready handshake to the downstream MAC datapath. It uses both ROM ports in parallel, fetching an even/odd word pair per access, and prefetches the next pair while the current pair drains. After the initial latency it sustains one weight per cycle.

## Interface
- ADDR_WIDTH, 4: ROM address width.
- DATA_WIDTH, 128: ROM word width.
- DEPTH, 16: ROM words.
- WEIGHT_WIDTH, 16: bits per weight. LANES = DATA_WIDTH/WEIGHT_WIDTH (8).
- NUM_WEIGHTS, 122: weights to stream. Requires NUM_WEIGHTS ≤ DEPTH·LANES.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to stream all weights.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final weight handshake.
- rom_addr_a  out  ADDR_WIDTH  ROM port A address (even word), registered.
- rom_addr_b  out  ADDR_WIDTH  ROM port B address (odd word), registered.
- rom_q_a  in  DATA_WIDTH  ROM port A data, valid 1 cycle after address.
- rom_q_b  in  DATA_WIDTH  ROM port B data.
- w_valid  out  1  weight beat valid.
- w_ready  in  1  downstream accepts the beat.
- w_data  out  WEIGHT_WIDTH  weight value.
- w_idx  out  $clog2(NUM_WEIGHTS)  weight index, 0..NUM_WEIGHTS-1.
- w_last  out  1  high with the beat for index NUM_WEIGHTS-1.

## Operation
- **Packing:** weight n is in word n/LANES, lane n%LANES. Lane 0 is bits [DATA_WIDTH-1 -: WEIGHT_WIDTH], i.e. MSB-first. Pair p = words 2p (port A) and 2p+1 (port B), giving 2·LANES weights.
- **IDLE:** busy=0, w_valid=0. On start=1, load rom_addr_a=0 and rom_addr_b=1, clear the index counter, set busy, and go to PRIME.
- **PRIME:** one wait cycle while the ROM registers q. Then go to LOAD.
- **LOAD:** capture rom_q_a and rom_q_b into the 2·DATA_WIDTH pair buffer, set lane pointer = 0, and assert w_valid. Advance the addresses to 2(p+1) and 2(p+1)+1, which starts the prefetch. Go to STREAM.
- **STREAM:**
  - w_data = buffer lane (lane pointer). Lanes 0..LANES-1 come from word A, LANES..2·LANES-1 from word B.
  - On each w_valid && w_ready, increment the lane pointer and w_idx.
  - If the accepted beat is the last lane of the pair and is not the final weight, reload the buffer directly from rom_q_a/rom_q_b (the prefetched pair), advance the addresses, and set lane pointer = 0. w_valid stays high, so there is no bubble.
  - If the accepted beat is the final weight (w_last), drop w_valid and go to DONE.
- **DONE:** pulse done for 1 cycle, clear busy, return to IDLE. rom_addr_a and rom_addr_b return to 0 and 1.
- **Pair-boundary safety:** the prefetch address is driven ≥2·LANES cycles before use, so rom_q is always stable at reload.
- **Odd-word overrun:** an odd-word address ≥ DEPTH on the final pair wraps modulo 2^ADDR_WIDTH. Its lanes are never emitted.
- **Partial last word:** the final word may be partially used (e.g. 122 weights: word 15 lanes 0–1 only). Emission stops at w_last and the remaining lanes are ignored.
- **start while busy:** ignored, no effect.
- **Backpressure:** while w_valid && !w_ready, w_data, w_idx and w_last hold stable and the addresses do not advance.

## Timing
- **Reset values:** busy=0, done=0, w_valid=0, w_data=0, w_idx=0, w_last=0, rom_addr_a=0, rom_addr_b=1. State = IDLE.
- **Start latency:** start is sampled at edge E0. Addresses become 0/1 after E0, q is valid after E1, and the buffer loads at E2. w_valid is high after E2 (first beat 2 cycles after start).
- **Throughput:** 1 weight/cycle with w_ready held high.
- **Stream duration:** with w_ready=1, the final beat is accepted at edge E2+NUM_WEIGHTS-1 (E123 for 122). done is high the cycle after that edge and busy falls with it.
- **Earliest restart:** the next start is accepted in the cycle after done.
- **Reset mid-operation:** rst_n low asynchronously forces all reset values immediately, with no done pulse. A new start is required after release.

## Test plan
- **Full stream, ROM loaded with the reference weight image, w_ready=1:** 122 beats expected.
  - idx0=16'hf690, idx7=16'hfbf1, idx8=16'hf83d, idx15=16'hff9f.
  - idx120=16'h0a68, idx121=16'h0611 with w_last=1.
  - w_valid continuous from E2 with no bubble at pair boundaries (idx15→16, 31→32).
  - done is a single pulse after E123.
- **Random w_ready (≈50%):** the same 122-value sequence in order, with w_data/w_idx/w_last stable during every stall and rom_addr unchanged while stalled on a pair's last lane.
- **Stall exactly at idx15 for 5 cycles, then accept:** idx16 = upper 16 bits of word 2 (16'hf85e) on the next beat.
- **start pulsed at idx 40 while busy:** no restart; the stream completes normally with a single done.
- **rst_n asserted at idx 60:** all outputs take reset values asynchronously and no done pulse appears. After release, start gives idx0=16'hf690 2 cycles later.
- **Back-to-back runs (start in the cycle after done):** the second run is identical to the first.

Source files
------------

// File: rtl/weight_stream_ctrl.sv
// Read sequencer for a packed dual-port weight ROM: fetches even/odd word pairs and streams
// the packed weights one per beat over valid/ready, prefetching the next pair while draining.
module weight_stream_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned NUM_WEIGHTS  = 122,
    localparam int unsigned LANES       = DATA_WIDTH / WEIGHT_WIDTH,
    localparam int unsigned IDX_WIDTH   = $clog2(NUM_WEIGHTS),
    localparam int unsigned LANE_WIDTH  = $clog2(2 * LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rom_addr_a,
    output logic [ADDR_WIDTH-1:0]   rom_addr_b,
    input  logic [DATA_WIDTH-1:0]   rom_q_a,
    input  logic [DATA_WIDTH-1:0]   rom_q_b,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [WEIGHT_WIDTH-1:0] w_data,
    output logic [IDX_WIDTH-1:0]    w_idx,
    output logic                    w_last
);

    if (NUM_WEIGHTS > DEPTH * LANES) begin : g_param_check
        $error("NUM_WEIGHTS exceeds ROM capacity");
    end

    typedef enum logic [2:0] {StIdle, StPrime, StLoad, StStream, StDone} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [2*DATA_WIDTH-1:0]   buf_q, buf_d;
    logic [LANE_WIDTH-1:0]     lane_q, lane_d;
    logic [IDX_WIDTH-1:0]      idx_q, idx_d;
    logic                      valid_q, valid_d;
    logic                      accept, last_lane, last_beat;
    logic [WEIGHT_WIDTH-1:0]   lanes [2*LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_a_q <= '0;
            addr_b_q <= ADDR_WIDTH'(1);
            buf_q    <= '0;
            lane_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            buf_q    <= buf_d;
            lane_q   <= lane_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
        end
    end

    assign accept    = valid_q && w_ready;
    assign last_lane = (lane_q == LANE_WIDTH'(2 * LANES - 1));
    assign last_beat = (idx_q == IDX_WIDTH'(NUM_WEIGHTS - 1));

    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        buf_d    = buf_q;
        lane_d   = lane_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_a_d = '0;
                    addr_b_d = ADDR_WIDTH'(1);
                    idx_d    = '0;
                    state_d  = StPrime;
                end
            end
            StPrime: state_d = StLoad;
            StLoad: begin
                buf_d    = {rom_q_a, rom_q_b};
                lane_d   = '0;
                valid_d  = 1'b1;
                addr_a_d = addr_a_q + ADDR_WIDTH'(2);
                addr_b_d = addr_b_q + ADDR_WIDTH'(2);
                state_d  = StStream;
            end
            StStream: begin
                if (accept) begin
                    if (last_beat) begin
                        valid_d  = 1'b0;
                        idx_d    = '0;
                        addr_a_d = '0;
                        addr_b_d = ADDR_WIDTH'(1);
                        state_d  = StDone;
                    end else if (last_lane) begin
                        // Prefetched pair has been on rom_q for many cycles; swap in, no bubble.
                        buf_d    = {rom_q_a, rom_q_b};
                        lane_d   = '0;
                        idx_d    = idx_q + IDX_WIDTH'(1);
                        addr_a_d = addr_a_q + ADDR_WIDTH'(2);
                        addr_b_d = addr_b_q + ADDR_WIDTH'(2);
                    end else begin
                        lane_d = lane_q + LANE_WIDTH'(1);
                        idx_d  = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane 0 sits at the MSB end of word A; word B follows as lanes LANES..2*LANES-1.
    always_comb begin
        for (int i = 0; i < 2 * LANES; i++) begin
            lanes[i] = buf_q[2*DATA_WIDTH-1-i*WEIGHT_WIDTH -: WEIGHT_WIDTH];
        end
    end

    assign busy       = (state_q == StPrime) || (state_q == StLoad) || (state_q == StStream);
    assign done       = (state_q == StDone);
    assign rom_addr_a = addr_a_q;
    assign rom_addr_b = addr_b_q;
    assign w_valid    = valid_q;
    assign w_data     = valid_q ? lanes[lane_q] : '0;
    assign w_idx      = idx_q;
    assign w_last     = valid_q && last_beat;

endmodule
